scc_mem_arbiter: RTL and testbench
==================================

# scc_mem_arbiter

Single-port memory arbiter and sequencer for the SCC core. It shares one memory bus between the instruction-fetch requester and the data load/store requester. Grants are serialized through a small state machine, and a transaction timeout is enforced. A combinational `stall` tells the top level when to gate the core clock, alongside the existing halt gating.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 15, max cycles waiting for `mem_ack` before abort (1..255)

Ports:
- `clk`  in  1  core clock
- `reset_s`  in  1  reset, synchronous, active-high
- `if_req`  in  1  instruction fetch request, level, held until `if_done`
- `if_addr`  in  AW  fetch address
- `if_data`  out  DW  fetched word, valid while `if_done`=1
- `if_done`  out  1  one-cycle completion pulse for fetch
- `d_read`  in  1  data read request, level
- `d_write`  in  1  data write request, level
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_rdata`  out  DW  read data, valid while `d_done`=1
- `d_done`  out  1  one-cycle completion pulse for data
- `mem_addr`  out  AW  memory address (registered)
- `mem_wdata`  out  DW  memory write data (registered)
- `mem_rd`  out  1  memory read strobe (registered)
- `mem_wr`  out  1  memory write strobe (registered)
- `mem_rdata`  in  DW  memory read data, sampled when `mem_ack`=1
- `mem_ack`  in  1  memory completion
- `stall`  out  1  combinational: (`if_req` & ~`if_done`) | ((`d_read`|`d_write`) & ~`d_done`)
- `timeout_err`  out  1  sticky timeout flag, cleared only by reset

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D, DONE.
- IDLE: if any request is asserted, choose a winner, latch address/data/direction, and go to BUSY_IF or BUSY_D. Otherwise stay.
- Arbitration (default): data has fixed priority over fetch.
- `d_read` and `d_write` both high: the access is treated as a write and the read is ignored.
- BUSY_*: `mem_rd` or `mem_wr` is held high with stable `mem_addr`/`mem_wdata` until `mem_ack`.
- On `mem_ack`: capture `mem_rdata` into the winner's data register and go to DONE. For writes, the captured data register is unchanged.
- DONE (1 cycle): the winner's `*_done`=1 and the strobes are low. No arbitration happens in this cycle. Next state is IDLE.
- Timeout: an 8-bit counter clears on entering BUSY_* and increments each BUSY cycle without ack. When it reaches `TIMEOUT`:
  - set `timeout_err`;
  - go to DONE with the winner's data register = 0;
  - `*_done` still pulses.
- `mem_ack` is ignored outside BUSY_*.
- Reset values: state IDLE; all strobes 0; `if_done` = `d_done` = 0; `if_data` = `d_rdata` = 0; `mem_addr` = `mem_wdata` = 0; `timeout_err` = 0; counter 0; round-robin pointer = data.
- Reset mid-transaction: everything returns to reset values on the next edge. No done pulse is generated.

## Timing
- Request seen in IDLE at cycle 0 → strobe high from cycle 1.
- Ack at cycle k (k≥1) → `*_done` and data at cycle k+1 → IDLE at cycle k+2.
- Minimum latency, request to done: 2 cycles (ack in cycle 1).
- Requester must drop or change its request by the cycle after `*_done`. A request still asserted in IDLE is a new request.
- `stall` is purely combinational, with no register delay.

## Configuration
- `SCC_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A 1-bit last-granted pointer flips to the other requester after each grant that completes (including timeout).
  - On contention, the requester not last granted wins.
  - After reset, data wins first.
- Undefined: fixed data priority, and the pointer logic is absent.

## Test plan
- Single fetch: `if_req`, `if_addr`=0x10, ack after 2 strobe cycles with `mem_rdata`=0xA5A5A5A5 → `mem_rd` cycles 1–2, `if_done`=1 with `if_data`=0xA5A5A5A5 at cycle 3, `stall` low only at cycle 3.
- Contention: `if_req` and `d_read` both asserted in IDLE → without macro, data is served first and then fetch; with macro, after reset data is first, then fetch, then data on repeat contention.
- Write: `d_write`, `d_addr`=0x40, `d_wdata`=0x12345678, ack in cycle 1 → `mem_wr`=1 in cycle 1 only, `d_done` in cycle 2, `d_rdata` unchanged.
- Timeout: `d_read` with no ack, `TIMEOUT`=15 → `mem_rd` high 15 cycles, then `d_done` with `d_rdata`=0 and `timeout_err`=1, which stays 1 until `reset_s`.
- Reset mid-BUSY: assert `reset_s` at the 3rd strobe cycle → strobes 0, no `*_done`, state IDLE the next cycle, and a later ack is ignored.
- Simultaneous `d_read` and `d_write` → only `mem_wr` asserts, and `d_done` pulses once.

Source files
------------

// File: rtl/scc_mem_arbiter.sv
// scc_mem_arbiter
// ---------------------------------------------------------------------------
// Shares one memory bus between the instruction-fetch requester and the data
// load/store requester. One transaction is in flight at a time, sequenced by
// an IDLE -> BUSY_IF/BUSY_D -> DONE -> IDLE state machine. A transaction that
// sees no mem_ack within TIMEOUT strobe cycles is aborted: it completes with
// zero data and sets the sticky timeout_err flag.
//
// Optional feature (compile-time macro SCC_ARB_ROUND_ROBIN_EN):
//   defined   - round-robin arbitration on contention (data wins first after
//               reset; afterwards the requester not granted last wins)
//   undefined - data has fixed priority over fetch
//
// Ports:
//   clk, reset_s          clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level) and address
//   if_data/if_done       fetched word, valid during the one-cycle if_done
//   d_read/d_write        data request (level); both high = write
//   d_addr/d_wdata        data address and write data
//   d_rdata/d_done        read data, valid during the one-cycle d_done
//   mem_addr/mem_wdata    registered memory address / write data
//   mem_rd/mem_wr         registered memory strobes, held until mem_ack
//   mem_rdata/mem_ack     memory read data and completion
//   stall                 combinational core-clock gating request
//   timeout_err           sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module scc_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_s,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_data,
    output logic          if_done,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

    state_t        state_reg, state_next;
    logic          win_d_reg;      // 1: data requester owns the transaction
    logic          is_wr_reg;      // transaction is a write
    logic [7:0]    cnt_reg;        // strobe cycles without ack
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic          mem_rd_reg, mem_wr_reg;
    logic [DW-1:0] if_data_reg, d_rdata_reg;
    logic          timeout_err_reg;

    logic d_req, any_req, grant_d, busy, timed_out, finish;

    assign d_req   = d_read | d_write;
    assign any_req = if_req | d_req;
    assign busy    = (state_reg == BUSY_IF) || (state_reg == BUSY_D);
    // Counter holds TIMEOUT-1 during the last permitted strobe cycle, so a
    // missing ack there makes this the TIMEOUT-th cycle and ends the access.
    assign timed_out = (cnt_reg == 8'(TIMEOUT - 1));
    assign finish    = busy & (mem_ack | timed_out);

`ifdef SCC_ARB_ROUND_ROBIN_EN
    // Preference for data on the next contention; reset makes data win first.
    logic prefer_d_reg;

    assign grant_d = d_req & (~if_req | prefer_d_reg);

    always_ff @(posedge clk) begin
        if (reset_s) begin
            prefer_d_reg <= 1'b1;
        end else if (finish) begin
            prefer_d_reg <= ~win_d_reg;
        end
    end
`else
    assign grant_d = d_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset_s) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:            if (any_req) state_next = grant_d ? BUSY_D : BUSY_IF;
            BUSY_IF, BUSY_D: if (mem_ack || timed_out) state_next = DONE;
            DONE:            state_next = IDLE;
            default:         state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        if_done     = (state_reg == DONE) & ~win_d_reg;
        d_done      = (state_reg == DONE) &  win_d_reg;
        mem_addr    = mem_addr_reg;
        mem_wdata   = mem_wdata_reg;
        mem_rd      = mem_rd_reg;
        mem_wr      = mem_wr_reg;
        if_data     = if_data_reg;
        d_rdata     = d_rdata_reg;
        timeout_err = timeout_err_reg;
        stall       = (if_req & ~if_done) | (d_req & ~d_done);
    end

    // Datapath: grant latching, strobes, data capture, timeout
    always_ff @(posedge clk) begin
        if (reset_s) begin
            win_d_reg       <= 1'b0;
            is_wr_reg       <= 1'b0;
            cnt_reg         <= 8'd0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            mem_rd_reg      <= 1'b0;
            mem_wr_reg      <= 1'b0;
            if_data_reg     <= '0;
            d_rdata_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        win_d_reg    <= grant_d;
                        is_wr_reg    <= grant_d & d_write;
                        mem_addr_reg <= grant_d ? d_addr : if_addr;
                        if (grant_d && d_write) begin
                            mem_wdata_reg <= d_wdata;
                        end
                        // A simultaneous read+write is a write only
                        mem_rd_reg <= ~(grant_d & d_write);
                        mem_wr_reg <=   grant_d & d_write;
                        cnt_reg    <= 8'd0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (mem_ack) begin
                        mem_rd_reg <= 1'b0;
                        mem_wr_reg <= 1'b0;
                        if (!is_wr_reg) begin
                            if (win_d_reg) d_rdata_reg <= mem_rdata;
                            else           if_data_reg <= mem_rdata;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                        if (timed_out) begin
                            mem_rd_reg      <= 1'b0;
                            mem_wr_reg      <= 1'b0;
                            timeout_err_reg <= 1'b1;
                            if (win_d_reg) d_rdata_reg <= '0;
                            else           if_data_reg <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scc_mem_arbiter.sv
module tb_scc_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset_s;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_data;
    logic          if_done;
    logic          d_read, d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic          timeout_err;

    scc_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_s(reset_s),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int txn_no = 0;

    // Reference state: last value each requester saw, sticky error, RR preference
    logic [DW-1:0] exp_if_data, exp_d_rdata;
    bit            exp_err_m;
    bit            prefer_d_m;

    typedef struct {
        bit          if_req;
        bit          d_read;
        bit          d_write;
        logic [31:0] if_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] rdata;
        int          delay;      // ack in this strobe cycle; > TIMEOUT means never
        bit          exp_win_d;
        bit          exp_wr;
        logic [31:0] exp_val;    // winner's data register during done
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input bit ir, input bit dr, input bit dw,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int dl, input bit ewd, input bit ewr,
                                input logic [31:0] ev, input bit ee);
        vec_t v;
        v.if_req = ir; v.d_read = dr; v.d_write = dw;
        v.if_addr = ia; v.d_addr = da; v.d_wdata = wd; v.rdata = rd;
        v.delay = dl; v.exp_win_d = ewd; v.exp_wr = ewr; v.exp_val = ev; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (txn %0d): got %h expected %h", name, txn_no, act, exp);
        end
    endtask

    // Runs one transaction. Entered just after a posedge with the cycle-0
    // request inputs applied and the arbiter idle; returns just after the
    // posedge following the done cycle, with the winner's request dropped.
    task automatic serve_one(input bit win_d, input bit is_wr, input int delay,
                             input logic [31:0] rdata, input logic [31:0] exp_val,
                             input bit exp_err);
        int n;
        logic [31:0] a, wd;
        logic exp_stall_done;
        n  = (delay > TIMEOUT) ? TIMEOUT : delay;
        a  = win_d ? d_addr : if_addr;
        wd = d_wdata;
        @(negedge clk);
        check("idle_rd", mem_rd, 0);
        check("idle_wr", mem_wr, 0);
        check("idle_if_done", if_done, 0);
        check("idle_d_done", d_done, 0);
        check("idle_stall", stall, 1);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            mem_ack   = (c == delay);
            mem_rdata = (c == delay) ? rdata : $urandom;
            @(negedge clk);
            check("busy_rd", mem_rd, !is_wr);
            check("busy_wr", mem_wr, is_wr);
            check("busy_addr", mem_addr, a);
            if (is_wr) check("busy_wdata", mem_wdata, wd);
            check("busy_if_done", if_done, 0);
            check("busy_d_done", d_done, 0);
            check("busy_stall", stall, 1);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        exp_stall_done = win_d ? if_req : (d_read | d_write);
        check("done_if_done", if_done, !win_d);
        check("done_d_done", d_done, win_d);
        check("done_rd", mem_rd, 0);
        check("done_wr", mem_wr, 0);
        check("done_err", timeout_err, exp_err);
        check("done_stall", stall, exp_stall_done);
        if (win_d) begin
            check("done_d_rdata", d_rdata, exp_val);
            check("hold_if_data", if_data, exp_if_data);
            exp_d_rdata = exp_val;
        end else begin
            check("done_if_data", if_data, exp_val);
            check("hold_d_rdata", d_rdata, exp_d_rdata);
            exp_if_data = exp_val;
        end
        $display("txn %0d: winner=%s %s strobe_cycles=%0d data=%h err=%0d",
                 txn_no, win_d ? "data" : "fetch", is_wr ? "write" : "read",
                 n, exp_val, exp_err);
        txn_no++;
        @(posedge clk); #1;
        if (win_d) begin
            d_read = 1'b0; d_write = 1'b0;
        end else begin
            if_req = 1'b0;
        end
    endtask

    initial begin
        bit win_d, is_wr, to;
        int delay, k;
        logic [31:0] rdata, ev;

        // Contention first, so both arbitration modes see data win right after reset
        vecs[0] = mk(1, 1, 0, 32'h20, 32'h48, 32'h0, 32'h33334444, 1, 1, 0, 32'h33334444, 0);
        vecs[1] = mk(1, 0, 0, 32'h20, 32'h48, 32'h0, 32'h55556666, 2, 0, 0, 32'h55556666, 0);
        vecs[2] = mk(1, 1, 0, 32'h24, 32'h4C, 32'h0, 32'h77778888, 1, 1, 0, 32'h77778888, 0);
        vecs[3] = mk(1, 0, 0, 32'h24, 32'h4C, 32'h0, 32'h9999AAAA, 1, 0, 0, 32'h9999AAAA, 0);
        vecs[4] = mk(1, 0, 0, 32'h10, 32'h0,  32'h0, 32'hA5A5A5A5, 2, 0, 0, 32'hA5A5A5A5, 0);
        vecs[5] = mk(0, 0, 1, 32'h0,  32'h40, 32'h12345678, 32'hDEADBEEF, 1, 1, 1, 32'h77778888, 0);
        vecs[6] = mk(0, 1, 0, 32'h0,  32'h44, 32'h0, 32'h11112222, 3, 1, 0, 32'h11112222, 0);
        vecs[7] = mk(0, 1, 1, 32'h0,  32'h50, 32'hCAFEF00D, 32'h0BADF00D, 2, 1, 1, 32'h11112222, 0);
        vecs[8] = mk(0, 1, 0, 32'h0,  32'h60, 32'h0, 32'hFFFFFFFF, 99, 1, 0, 32'h0, 1);
        vecs[9] = mk(1, 0, 0, 32'h30, 32'h0,  32'h0, 32'h13579BDF, 1, 0, 0, 32'h13579BDF, 1);

        reset_s = 1'b1;
        if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_if_done", if_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_if_data", if_data, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_err", timeout_err, 0);
        check("rst_stall", stall, 0);
        @(posedge clk); #1;
        reset_s = 1'b0;
        exp_if_data = 0; exp_d_rdata = 0; exp_err_m = 0; prefer_d_m = 1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            if_req = vecs[i].if_req; d_read = vecs[i].d_read; d_write = vecs[i].d_write;
            if_addr = vecs[i].if_addr; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            serve_one(vecs[i].exp_win_d, vecs[i].exp_wr, vecs[i].delay, vecs[i].rdata,
                      vecs[i].exp_val, vecs[i].exp_err);
        end

        // Ack outside a transaction has no effect; error flag remains set
        if_req = 0; d_read = 0; d_write = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b1; mem_rdata = 32'hFFFF0000 + c;
            @(negedge clk);
            check("stray_ack_d_done", d_done, 0);
            check("stray_ack_if_done", if_done, 0);
            check("stray_ack_rd", mem_rd, 0);
            check("stray_ack_d_rdata", d_rdata, exp_d_rdata);
            check("stray_ack_if_data", if_data, exp_if_data);
            check("sticky_err", timeout_err, 1);
            check("idle_stall_low", stall, 0);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;

        // Reset during the 3rd strobe cycle of a read
        d_read = 1'b1; d_addr = 32'h70;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 3) reset_s = 1'b1;
            @(negedge clk);
            check("pre_rst_rd", mem_rd, 1);
            check("pre_rst_addr", mem_addr, 32'h70);
        end
        @(posedge clk); #1;
        reset_s = 1'b0; d_read = 1'b0;
        @(negedge clk);
        check("mid_rst_rd", mem_rd, 0);
        check("mid_rst_wr", mem_wr, 0);
        check("mid_rst_d_done", d_done, 0);
        check("mid_rst_if_done", if_done, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_d_rdata", d_rdata, 0);
        check("mid_rst_if_data", if_data, 0);
        check("mid_rst_err", timeout_err, 0);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h12121212;
        @(negedge clk);
        check("late_ack_d_done", d_done, 0);
        check("late_ack_rd", mem_rd, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_d_done2", d_done, 0);
        check("late_ack_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        exp_if_data = 0; exp_d_rdata = 0; exp_err_m = 0; prefer_d_m = 1;

        // Randomized traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            if (!if_req && $urandom_range(1, 0) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!(d_read | d_write)) begin
                k = $urandom_range(3, 0);
                d_read  = (k == 1) || (k == 3);
                d_write = (k >= 2);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if (!if_req && !(d_read | d_write)) begin
                d_read = 1'b1; d_addr = $urandom;
            end
`ifdef SCC_ARB_ROUND_ROBIN_EN
            win_d = (d_read | d_write) && (!if_req || prefer_d_m);
            prefer_d_m = !win_d;
`else
            win_d = d_read | d_write;
`endif
            is_wr = win_d && d_write;
            delay = $urandom_range(18, 1);
            rdata = $urandom;
            to    = delay > TIMEOUT;
            ev    = to ? 32'h0 : (is_wr ? exp_d_rdata : rdata);
            exp_err_m = exp_err_m | to;
            serve_one(win_d, is_wr, delay, rdata, ev, exp_err_m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
